sumador_rizado_seg: RTL
=======================

# sumador_rizado_seg

Parametrised, pipelined successor to the 8-bit ripple-carry adder used in the power-analysis flow. It adds two WIDTH-bit operands plus carry-in, splitting the carry chain into STAGES registered slices. This trades latency for a short critical path. It runs with a valid/ready handshake on both sides. It also carries an output toggle counter that feeds switching-activity figures to the power-analysis benches. It sits between the operand source and any downstream consumer in the datapath under power study.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of STAGES
- STAGES, 4, pipeline slices (1..WIDTH); slice width SW = WIDTH/STAGES
- CNT_W, 16, toggle counter width
- PwrC, 0, power-characterisation tag; passed to sub-modules, no functional effect
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand word present
- in_ready  out  1  block accepts operand word this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry-in
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  sum, LSB-first slice order, bit i = sum bit i
- co  out  1  carry-out of bit WIDTH-1
- tog_clr  in  1  synchronous clear of toggle counter
- tog_count  out  CNT_W  accumulated output-bit toggles, saturating

## Operation
- Stage k (0..STAGES-1) adds slice k (bits k*SW .. k*SW+SW-1) of a, b with the carry registered by stage k-1 (stage 0 uses ci).
- Each stage register holds: valid bit, the sum bits already computed, the carry out of its slice, and the not-yet-added upper slices of a and b.
- Final stage register drives s, co, out_valid directly; no output combinational logic except the handshake.
- Global stall: stall = out_valid & ~out_ready. While stall is high, every stage register holds. Otherwise all stages advance one position per cycle.
- in_ready = ~stall. An operand is captured when in_valid & in_ready.
- Bubbles are not compressed; an empty stage advances like a full one.
- Arithmetic: {co, s} = a + b + ci, full WIDTH+1-bit result, no truncation, no overflow flag.
- Toggle counter: on each accepted result (out_valid & out_ready), tog_count += popcount(s ^ last_s), then last_s <= s.
  - The count saturates at 2^CNT_W-1 and never wraps.
  - last_s resets to 0.
- tog_clr sets tog_count to 0 and has priority over a same-cycle increment. last_s is still updated on that cycle.

## Timing
- Latency: a word accepted at cycle n appears with out_valid at cycle n+STAGES if there is no stall. Each stall cycle adds one.
- Throughput: one result per cycle when out_ready is held high.
- s, co, and the slice data are stable while out_valid & ~out_ready, and out_valid is not retracted.
- Reset values:
  - all stage valid bits 0, so out_valid = 0
  - s = 0, co = 0, tog_count = 0, last_s = 0
  - in_ready = 1 from the first cycle after reset
- Reset mid-operation discards every in-flight word. No result from before reset ever appears after it.
- Simultaneous events:
  - A word accepted into stage 0 in the same cycle the final stage hands off is legal and is required for full throughput.
  - tog_clr together with a handoff is resolved as above.
- STAGES = 1 degenerates to a single registered ripple adder, latency 1.

## Structure
- sumador_pkg holds:
  - default parameter constants (WIDTH, STAGES, CNT_W)
  - a stage-register struct: valid, partial sum, carry, remaining a/b
- Sub-module sumador_tramo: combinational SW-bit ripple slice (a, b, ci -> s, co), built from chained one-bit full adders. It is instantiated once per stage, with PwrC passed through.
- Toggle popcount is a local function inside sumador_rizado_seg; no separate module.

## Test plan
All scenarios use WIDTH=16, STAGES=4.
- Carry ripple across slices: a=0xFFFF, b=0x0001, ci=0, out_ready=1 -> four cycles later s=0x0000, co=1, out_valid=1 for exactly one cycle.
- Back-to-back: 0x1234+0x1111 ci=0, then 0x8000+0x8000 ci=1, then 0x00FF+0x0F01 ci=0 on consecutive cycles -> s=0x2345/co=0, s=0x0001/co=1, s=0x1000/co=0 on consecutive cycles from latency 4.
- Stall:
  - Stimulus: hold out_ready=0 for 3 cycles while out_valid=1.
  - Required: s and co remain constant and in_ready=0 for those 3 cycles. No word is lost or duplicated after release, verified against a reference queue over 200 random words with random out_ready.
- Reset mid-operation: assert reset with 3 words in flight -> next cycle out_valid=0, tog_count=0. Those words never emerge, and the first word accepted after reset emerges with latency 4.
- Toggle count:
  - Results 0x0000, then 0xFFFF, then 0x00FF are accepted -> tog_count = 0, 16, 24.
  - tog_clr asserted with the 0x00FF handoff -> tog_count=0 and the next result 0x0000 gives 8.
- Saturation: with CNT_W=4, accept 0xFFFF then 0x0000 -> tog_count=15 and holds at 15 on further toggles.

Source files
------------

// File: rtl/sumador_pkg.sv
// ---------------------------------------------------------------------------
// sumador_pkg
// Shared constants and types for the pipelined ripple-carry adder.
//   DefWidth / DefStages / DefCntW : default top-level parameter values
//   MaxWidth                       : widest operand the stage record can hold
//   stage_t                        : contents of one pipeline stage register
// ---------------------------------------------------------------------------
package sumador_pkg;

    localparam int unsigned DefWidth  = 16;
    localparam int unsigned DefStages = 4;
    localparam int unsigned DefCntW   = 16;

    // The stage record is sized for the widest supported operand so one type
    // serves every configuration. Bits above WIDTH are never set and fold away.
    localparam int unsigned MaxWidth  = 64;

    typedef struct packed {
        logic                valid;  // stage holds a word
        logic [MaxWidth-1:0] sum;    // sum bits produced so far, LSB-first
        logic                carry;  // carry out of the last slice added
        logic [MaxWidth-1:0] a;      // operand A, consumed slices zeroed
        logic [MaxWidth-1:0] b;      // operand B, consumed slices zeroed
    } stage_t;

endpackage

// File: rtl/sumador_tramo.sv
// ---------------------------------------------------------------------------
// sumador_tramo
// Combinational SW-bit ripple-carry slice built from chained one-bit full
// adders.
//   a, b : slice operands
//   ci   : carry into bit 0 of the slice
//   s    : slice sum
//   co   : carry out of the slice MSB
// PwrC is a power-characterisation tag with no functional effect.
// ---------------------------------------------------------------------------
module sumador_tramo #(
    parameter int unsigned SW   = 4,
    parameter int          PwrC = 0
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co
);

    // Negative tags are reserved by the power flow.
    if (PwrC < 0) begin : g_bad_tag
        $error("sumador_tramo: PwrC must be non-negative");
    end

    // Carry walks bit by bit through one full adder per position; a single
    // block keeps the chain from looking like a combinational loop.
    logic carry;

    always_comb begin
        carry = ci;
        s     = '0;
        for (int i = 0; i < int'(SW); i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/sumador_rizado_seg.sv
// ---------------------------------------------------------------------------
// sumador_rizado_seg
// Pipelined ripple-carry adder: {co, s} = a + b + ci, with the carry chain cut
// into STAGES registered slices of SW = WIDTH/STAGES bits. Valid/ready on both
// sides with a single global stall. An output toggle counter accumulates the
// Hamming distance between consecutive accepted results, saturating.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (a, b, ci)
//   out_valid / out_ready : result handshake (s, co)
//   tog_clr               : synchronous clear of tog_count (wins over update)
//   tog_count             : saturating output toggle count
// ---------------------------------------------------------------------------
module sumador_rizado_seg
    import sumador_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned STAGES = DefStages,
    parameter int unsigned CNT_W  = DefCntW,
    parameter int          PwrC   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    input  logic             tog_clr,
    output logic [CNT_W-1:0] tog_count
);

    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned PopW = $clog2(WIDTH + 1);
    // Wide enough that counter + popcount cannot overflow before saturation.
    localparam int unsigned AccW = ((CNT_W > PopW) ? CNT_W : PopW) + 1;

    if ((STAGES == 0) || ((WIDTH % STAGES) != 0) || (WIDTH > MaxWidth)) begin : g_bad_params
        $error("sumador_rizado_seg: WIDTH must be a non-zero multiple of STAGES, <= MaxWidth");
    end

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Next contents of stage k: inherit the predecessor, insert slice k of the
    // sum, record its carry, and zero the operand slice just consumed.
    function automatic stage_t advance(input stage_t          prev,
                                       input logic [SW-1:0]   slice_sum,
                                       input logic            slice_carry,
                                       input int unsigned     k);
        stage_t nxt;
        nxt                   = prev;
        nxt.sum[k*SW +: SW]   = slice_sum;
        nxt.carry             = slice_carry;
        nxt.a[k*SW +: SW]     = '0;
        nxt.b[k*SW +: SW]     = '0;
        return nxt;
    endfunction

    function automatic logic [PopW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PopW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            n = n + PopW'(v[i]);
        end
        return n;
    endfunction

    // -----------------------------------------------------------------------
    // Pipeline
    // -----------------------------------------------------------------------
    stage_t          stage_in [STAGES];  // what each stage's adder sees
    stage_t          pipe_d   [STAGES];
    stage_t          pipe_q   [STAGES];
    logic [SW-1:0]   slice_s  [STAGES];
    logic            slice_co [STAGES];
    logic            stall;

    // Stage 0 is fed straight from the operand port; ci rides in the carry
    // field so every stage adds its slice with the predecessor's carry.
    assign stage_in[0] = '{valid: in_valid,
                           sum:   '0,
                           carry: ci,
                           a:     MaxWidth'(a),
                           b:     MaxWidth'(b)};

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        if (k > 0) begin : g_link
            assign stage_in[k] = pipe_q[k-1];
        end

        sumador_tramo #(
            .SW   (SW),
            .PwrC (PwrC)
        ) u_tramo (
            .a  (stage_in[k].a[k*SW +: SW]),
            .b  (stage_in[k].b[k*SW +: SW]),
            .ci (stage_in[k].carry),
            .s  (slice_s[k]),
            .co (slice_co[k])
        );

        assign pipe_d[k] = advance(stage_in[k], slice_s[k], slice_co[k], k);
    end

    // One global stall: a held result freezes every stage, bubbles included.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                pipe_q[k] <= '0;
            end
        end else if (!stall) begin
            pipe_q <= pipe_d;
        end
    end

    assign out_valid = pipe_q[STAGES-1].valid;
    assign s         = pipe_q[STAGES-1].sum[WIDTH-1:0];
    assign co        = pipe_q[STAGES-1].carry;

    // -----------------------------------------------------------------------
    // Output toggle counter
    // -----------------------------------------------------------------------
    logic             handoff;
    logic [AccW-1:0]  tog_sum;
    logic [CNT_W-1:0] tog_sat;
    logic [CNT_W-1:0] tog_q;
    logic [WIDTH-1:0] last_s_q;

    assign handoff = out_valid & out_ready;
    assign tog_sum = AccW'(tog_q) + AccW'(popcount(s ^ last_s_q));
    assign tog_sat = (tog_sum > AccW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : tog_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            tog_q    <= '0;
            last_s_q <= '0;
        end else begin
            if (tog_clr) begin
                tog_q <= '0;
            end else if (handoff) begin
                tog_q <= tog_sat;
            end
            // last_s tracks every accepted result, even on a clear cycle.
            if (handoff) begin
                last_s_q <= s;
            end
        end
    end

    assign tog_count = tog_q;

endmodule
